// File: rtl/fifo_pkg.sv
// fifo_pkg: shared depth helper and error-flag bit indices for the FIFO controller.
package fifo_pkg;
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_W = 2;
    typedef logic [ERR_W-1:0] err_t;
    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: AW+1-bit wrap-bit pointer with enable and async active-high reset.
module fifo_ptr #(
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [AW:0] p
);
    always_ff @(posedge clk or posedge rst)
        if (rst) p <= '0;
        else if (en) p <= p + 1'b1;
endmodule

// File: rtl/fifo_ctl.sv
// fifo_ctl: parametrised FIFO address/flag controller with a registered fill level.
// Sticky ovf/unf error flags are built only when FIFO_ERR_EN is defined.
module fifo_ctl
    import fifo_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    output logic [AW-1:0] wa,
    output logic [AW-1:0] ra,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic [AW:0]   afthr,
    input  logic [AW:0]   aethr,
    output logic          afull,
    output logic          aempty,
    input  logic          errclr,
    output logic          ovf,
    output logic          unf
);
    logic [AW:0] wp, rp;
    logic we, re;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign we = wr && !full;
    assign re = rd && !empty;
    assign wa = wp[AW-1:0];
    assign ra = rp[AW-1:0];
    fifo_ptr #(.AW(AW)) u_wp (.clk(clk), .rst(rst), .en(we), .p(wp));
    fifo_ptr #(.AW(AW)) u_rp (.clk(clk), .rst(rst), .en(re), .p(rp));
    // level is kept as its own register so flag decode avoids a subtractor
    always_ff @(posedge clk or posedge rst)
        if (rst) level <= '0;
        else if (we != re) level <= we ? level + 1'b1 : level - 1'b1;
    assign afull = level >= afthr;
    assign aempty = level <= aethr;
`ifdef FIFO_ERR_EN
    err_t err, err_set;
    always_comb begin
        err_set = '0;
        err_set[ERR_OVF] = wr && full;
        err_set[ERR_UNF] = rd && empty;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) err <= '0;
        else err <= (errclr ? '0 : err) | err_set;
    assign ovf = err[ERR_OVF];
    assign unf = err[ERR_UNF];
`else
    logic unused_errclr;
    assign unused_errclr = errclr;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif
endmodule

// File: doc/fifo_ctl.md
# fifo_ctl

Parametrised FIFO address and flag controller, the successor to the fixed 8-entry controller. It generates write and read addresses for an external dual-port RAM of depth 2^AW and carries a registered fill level. Full and empty come from a wrap-bit pointer comparison; almost-full and almost-empty use programmable thresholds. It sits between DSP producers and consumers (sample buffers, command queues) wherever the buffer depth differs from 8.

## Interface
Parameters:
- AW, 3: address width; depth = 2^AW entries, AW in 2..12.

Ports:
- clk  in  1  master clock, all logic on rising edge.
- rst  in  1  master reset, asynchronous, active-high.
- wr  in  1  write request; a write is accepted when wr & ~full.
- rd  in  1  read confirm; a read is accepted when rd & ~empty.
- wa  out  AW  write address, from the low bits of the write pointer.
- ra  out  AW  read address, from the low bits of the read pointer.
- full  out  1  FIFO holds 2^AW entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  AW+1  current entry count, 0..2^AW.
- afthr  in  AW+1  almost-full threshold, treated as static.
- aethr  in  AW+1  almost-empty threshold, treated as static.
- afull  out  1  level >= afthr.
- aempty  out  1  level <= aethr.
- errclr  in  1  clears the sticky error flags (only with FIFO_ERR_EN).
- ovf  out  1  sticky overflow (only with FIFO_ERR_EN).
- unf  out  1  sticky underflow (only with FIFO_ERR_EN).

## Operation
- Pointers wp and rp are AW+1 bits wide. The MSB is the wrap bit. No direction flip-flop.
- empty = (wp == rp).
- full = (wp[AW] != rp[AW]) & (wp[AW-1:0] == rp[AW-1:0]).
- Accepted write: wp <= wp+1. Accepted read: rp <= rp+1. Both wrap modulo 2^(AW+1).
- Acceptance is evaluated on the flags of the current cycle:
  - Full with wr & rd: the read is accepted and the write is rejected. Next cycle level = 2^AW-1.
  - Empty with wr & rd: the write is accepted and the read is rejected. Next cycle level = 1.
  - Neither full nor empty with wr & rd: both are accepted and level is unchanged.
- level is a register, separate from the pointer difference:
  - +1 on write-only acceptance.
  - -1 on read-only acceptance.
  - Held otherwise.
  - Invariant: level == wp - rp (mod 2^(AW+1)) at all times. The testbench checks this.
- afull and aempty are combinational from the registered level and the thresholds.
  - afthr = 0 forces afull = 1.
  - aethr >= 2^AW forces aempty = 1.
- Reset values: wp = rp = 0, level = 0, wa = ra = 0, empty = 1, full = 0, ovf = unf = 0. afull and aempty follow the thresholds with level = 0.
- Reset asserted mid-operation clears all state immediately without waiting for a clock edge. Any in-flight request is discarded.

## Timing
- full, empty, wa and ra are combinational from registers: valid in the cycle after the accepting edge, with no added latency.
- The data RAM write uses wa in the same cycle as the accepted wr.
- The read data at ra is valid while ~empty. rd confirms consumption (show-ahead), and ra advances on the next edge.
- level, afull and aempty update one edge after an accepted access, in step with full and empty.
- Target: 200 MHz or better at AW = 10.

## Configuration
- FIFO_ERR_EN defined:
  - ovf sets on wr & full.
  - unf sets on rd & empty.
  - Both hold until errclr. The clear takes effect on the next edge.
  - A set and a clear in the same cycle: set wins.
- FIFO_ERR_EN undefined:
  - ovf and unf are tied to 0.
  - errclr is ignored.
  - No error registers are built.
- Acceptance behaviour is identical in both builds.

## Structure
- Package fifo_pkg holds:
  - Localparam function for depth (1 << AW).
  - Error flag bit-index constants shared with status registers.
- Sub-module fifo_ptr: an AW+1-bit pointer with enable and asynchronous reset, instantiated once for wp and once for rp.
- Level counter, flag decode and error logic live in fifo_ctl.

## Test plan
All scenarios use AW = 3, afthr = 6, aethr = 1.
- Reset, then 8 writes with no reads:
  - After the 8th, full = 1, empty = 0, level = 8, afull = 1, wa = 0.
  - The 9th wr leaves wa and level unchanged; ovf = 1 with FIFO_ERR_EN.
- From full, 8 reads:
  - ra steps 0..7 then returns to 0.
  - level reaches 0 and empty = 1; aempty asserts at level = 1.
  - A further rd sets unf with FIFO_ERR_EN.
- Simultaneous wr & rd:
  - At level = 4 for 20 cycles: level stays 4, and wa and ra wrap past 7 twice.
  - At full: level goes 8 -> 7.
  - At empty: level goes 0 -> 1.
- Random wr/rd for 10,000 cycles: level == wp - rp every cycle, full and empty never both 1, and a scoreboard shows no data loss.
- Asynchronous rst pulse between edges while level = 5: all outputs reach reset values before the next edge. Operation resumes cleanly.
- FIFO_ERR_EN: errclr coinciding with a new overflow keeps ovf = 1; errclr alone clears ovf on the next edge.
